// File: rtl/eth_link_mon_pkg.sv
// Shared state encoding and timer sizing helper for the PHY link monitor.
package eth_link_mon_pkg;

  localparam logic [1:0] LS_DOWN    = 2'd0;
  localparam logic [1:0] LS_QUAL    = 2'd1;
  localparam logic [1:0] LS_UP      = 2'd2;
  localparam logic [1:0] LS_RETRAIN = 2'd3;

  typedef enum logic [1:0] {
    ST_DOWN    = LS_DOWN,
    ST_QUAL    = LS_QUAL,
    ST_UP      = LS_UP,
    ST_RETRAIN = LS_RETRAIN
  } link_state_e;

  // Width able to hold the largest of the three timer limits (inclusive).
  function automatic int clog2_max(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/eth_link_mon_sat_cnt.sv
// Saturating statistics counter; the sum is formed one bit wider so overflow is caught.
module eth_link_mon_sat_cnt #(
  parameter int CNT_WIDTH = 32,
  parameter int INC_WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [INC_WIDTH-1:0] inc,
  output logic [CNT_WIDTH-1:0] count
);

  logic [CNT_WIDTH:0] sum;

  assign sum = {1'b0, count} + (CNT_WIDTH + 1)'(inc);

  always_ff @(posedge clk) begin
    if (!rst_n || clear)    count <= '0;
    else if (sum[CNT_WIDTH]) count <= '1;
    else                     count <= sum[CNT_WIDTH-1:0];
  end

endmodule

// File: rtl/eth_phy_link_monitor.sv
// Debounced link supervisor with GT RX reset request on prolonged loss of lock.
// Statistics counters are built only when ETH_LINK_MON_STATS_EN is defined.
module eth_phy_link_monitor
  import eth_link_mon_pkg::*;
#(
  parameter int UP_DEBOUNCE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int CNT_WIDTH           = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 phy_rx_block_lock,
  input  logic                 phy_rx_high_ber,
  input  logic                 phy_rx_status,
  input  logic [6:0]           phy_rx_error_count,
  input  logic                 phy_rx_bad_block,
  input  logic                 phy_rx_sequence_error,
  input  logic                 cfg_enable,
  input  logic                 stats_clear,
  output logic                 link_up,
  output logic [1:0]           link_state,
  output logic                 link_up_pulse,
  output logic                 link_down_pulse,
  output logic                 rx_reset_req,
  output logic [CNT_WIDTH-1:0] stat_err_total,
  output logic [CNT_WIDTH-1:0] stat_bad_block,
  output logic [CNT_WIDTH-1:0] stat_seq_err,
  output logic [CNT_WIDTH-1:0] stat_link_flaps
);

  localparam int TW = clog2_max(LOCK_TIMEOUT_CYCLES, UP_DEBOUNCE_CYCLES, RESET_PULSE_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] UP_LAST = TW'(UP_DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] RT_LEN  = TW'(RESET_PULSE_CYCLES);

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    return (&v) ? v : v + TW'(1);
  endfunction

  link_state_e   state, nxt;
  logic [TW-1:0] to_cnt, to_nxt;
  logic [TW-1:0] ph_cnt, ph_nxt;   // debounce count in QUAL, pulse count in RETRAIN
  logic          good;

  assign good       = phy_rx_status && phy_rx_block_lock && !phy_rx_high_ber;
  assign link_state = state;

  always_comb begin
    nxt    = state;
    to_nxt = to_cnt;
    ph_nxt = ph_cnt;
    case (state)
      ST_DOWN: begin
        if (!cfg_enable) to_nxt = '0;
        else if (good) begin
          nxt    = ST_QUAL;
          ph_nxt = '0;
        end else if (to_cnt >= TO_LAST) begin
          nxt    = ST_RETRAIN;
          to_nxt = '0;
          ph_nxt = '0;
        end else to_nxt = sat_inc(to_cnt);
      end
      ST_QUAL: begin
        to_nxt = sat_inc(to_cnt);
        if (!good || !cfg_enable) nxt = ST_DOWN;
        else if (ph_cnt >= UP_LAST) nxt = ST_UP;
        else ph_nxt = sat_inc(ph_cnt);
      end
      ST_UP: begin
        to_nxt = '0;
        if (!good || !cfg_enable) nxt = ST_DOWN;
      end
      default: begin
        // RETRAIN holds one extra cycle with the request low before re-arming DOWN.
        to_nxt = '0;
        if (!cfg_enable || ph_cnt >= RT_LEN) nxt = ST_DOWN;
        else ph_nxt = sat_inc(ph_cnt);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_DOWN;
      to_cnt          <= '0;
      ph_cnt          <= '0;
      link_up         <= 1'b0;
      link_up_pulse   <= 1'b0;
      link_down_pulse <= 1'b0;
      rx_reset_req    <= 1'b0;
    end else begin
      state           <= nxt;
      to_cnt          <= to_nxt;
      ph_cnt          <= ph_nxt;
      link_up         <= (nxt == ST_UP);
      link_up_pulse   <= (state == ST_QUAL) && (nxt == ST_UP);
      link_down_pulse <= (state == ST_UP) && (nxt == ST_DOWN);
      rx_reset_req    <= (nxt == ST_RETRAIN) && (ph_nxt < RT_LEN);
    end
  end

`ifdef ETH_LINK_MON_STATS_EN
  logic flap;
  assign flap = (state == ST_UP) && (nxt == ST_DOWN);

  eth_link_mon_sat_cnt #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(7)) u_err (
    .clk(clk), .rst_n(rst_n), .clear(stats_clear), .inc(phy_rx_error_count), .count(stat_err_total));
  eth_link_mon_sat_cnt #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_bad (
    .clk(clk), .rst_n(rst_n), .clear(stats_clear), .inc(phy_rx_bad_block), .count(stat_bad_block));
  eth_link_mon_sat_cnt #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_seq (
    .clk(clk), .rst_n(rst_n), .clear(stats_clear), .inc(phy_rx_sequence_error), .count(stat_seq_err));
  eth_link_mon_sat_cnt #(.CNT_WIDTH(CNT_WIDTH), .INC_WIDTH(1)) u_flap (
    .clk(clk), .rst_n(rst_n), .clear(stats_clear), .inc(flap), .count(stat_link_flaps));
`else
  logic unused_stats;
  assign unused_stats    = ^{stats_clear, phy_rx_error_count, phy_rx_bad_block, phy_rx_sequence_error};
  assign stat_err_total  = '0;
  assign stat_bad_block  = '0;
  assign stat_seq_err    = '0;
  assign stat_link_flaps = '0;
`endif

endmodule
